multicycle_controller: RTL and testbench

Multi-cycle sequencing controller for the RISC-V datapath. It issues the same per-instruction control signals as the single-cycle decode, but spreads each instruction across FETCH/DECODE/EXEC/MEM/WB states. It also adds PC/IR write enables, instruction and data memory request/ready handshakes, and PC source selection. It replaces the combinational decoder when the core shares a single ALU and waits on memories with variable latency.

---
 rtl/multicycle_controller_if.sv | 52 +++++
 rtl/multicycle_controller.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_if
//  Description : Bundles the signals between the multi-cycle sequencing
//                controller and the datapath/memories.
//                master : controller side. It drives the control outputs and
//                         receives opcode, zero and the memory ready flags.
//                slave  : datapath side, with the opposite directions.
//  Signals     : opcode[6:0], zero, imem_ready, dmem_ready     (dp -> ctrl)
//                imem_req, ir_write_en, pc_write_en, pc_src[1:0], jump,
//                branch, mem_read_en, mem_write_en, mem_to_reg, alu_src,
//                reg_write_en, alu_op[1:0], illegal, retire,
//                state[2:0]                                    (ctrl -> dp)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic       zero;
  logic       imem_ready;
  logic       dmem_ready;

  logic       imem_req;
  logic       ir_write_en;
  logic       pc_write_en;
  logic [1:0] pc_src;
  logic       jump;
  logic       branch;
  logic       mem_read_en;
  logic       mem_write_en;
  logic       mem_to_reg;
  logic       alu_src;
  logic       reg_write_en;
  logic [1:0] alu_op;
  logic       illegal;
  logic       retire;
  logic [2:0] state;

  modport master (
    input  opcode, zero, imem_ready, dmem_ready,
    output imem_req, ir_write_en, pc_write_en, pc_src, jump, branch,
           mem_read_en, mem_write_en, mem_to_reg, alu_src, reg_write_en,
           alu_op, illegal, retire, state
  );

  modport slave (
    output opcode, zero, imem_ready, dmem_ready,
    input  imem_req, ir_write_en, pc_write_en, pc_src, jump, branch,
           mem_read_en, mem_write_en, mem_to_reg, alu_src, reg_write_en,
           alu_op, illegal, retire, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Multi-cycle RISC-V sequencing controller. It steps each
//                instruction through FETCH/DECODE/EXEC/MEM/WB and generates
//                the datapath controls, PC/IR write enables and the memory
//                request handshakes.
//  Ports       : clk     - rising-edge clock
//                rst_n   - asynchronous active-low reset
//                ctrl_if - multicycle_controller_if.master control bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  multicycle_controller_if.master       ctrl_if
);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_op_q;

  logic       w_imem_req, w_ir_write_en, w_pc_write_en, w_jump, w_branch;
  logic       w_mem_read_en, w_mem_write_en, w_mem_to_reg, w_alu_src;
  logic       w_reg_write_en, w_illegal, w_retire;
  logic [1:0] w_pc_src, w_alu_op;

  // State register. The opcode is captured in DECODE so that later states
  // do not depend on the IR output staying stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
      r_op_q  <= 7'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op_q <= ctrl_if.opcode;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_imem_req     = 1'b0;
    w_ir_write_en  = 1'b0;
    w_pc_write_en  = 1'b0;
    w_pc_src       = 2'b00;
    w_jump         = 1'b0;
    w_branch       = 1'b0;
    w_mem_read_en  = 1'b0;
    w_mem_write_en = 1'b0;
    w_mem_to_reg   = 1'b0;
    w_alu_src      = 1'b0;
    w_reg_write_en = 1'b0;
    w_alu_op       = 2'b00;
    w_illegal      = 1'b0;
    w_retire       = 1'b0;

    case (r_state)
      S_RST: begin
        w_next = S_FETCH;
      end

      S_FETCH: begin
        w_imem_req = 1'b1;
        if (ctrl_if.imem_ready) begin
          w_ir_write_en = 1'b1;
          w_next        = S_DECODE;
        end
      end

      // op_q is only written at the end of this cycle, so the legality
      // check must use the live opcode input.
      S_DECODE: begin
        case (ctrl_if.opcode)
          c_OP_R, c_OP_I, c_OP_LOAD, c_OP_STORE, c_OP_BRANCH, c_OP_JAL: begin
            w_next = S_EXEC;
          end
          default: begin
            w_illegal     = 1'b1;
            w_pc_write_en = 1'b1;
            w_retire      = 1'b1;
            w_next        = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        case (r_op_q)
          c_OP_R: begin
            w_next = S_WB;
          end
          c_OP_I: begin
            w_alu_op  = 2'b01;
            w_alu_src = 1'b1;
            w_next    = S_WB;
          end
          c_OP_LOAD, c_OP_STORE: begin
            w_alu_op  = 2'b01;
            w_alu_src = 1'b1;
            w_next    = S_MEM;
          end
          c_OP_BRANCH: begin
            w_branch      = 1'b1;
            w_alu_op      = 2'b10;
            w_pc_write_en = 1'b1;
            w_pc_src      = ctrl_if.zero ? 2'b01 : 2'b00;
            w_retire      = 1'b1;
            w_next        = S_FETCH;
          end
          c_OP_JAL: begin
            w_jump         = 1'b1;
            w_reg_write_en = 1'b1;
            w_pc_write_en  = 1'b1;
            w_pc_src       = 2'b10;
            w_retire       = 1'b1;
            w_next         = S_FETCH;
          end
          default: begin
            w_next = S_FETCH;
          end
        endcase
      end

      // The address operands stay selected for the whole access. Read and
      // write enables are keyed on distinct opcodes, so they never overlap.
      S_MEM: begin
        w_alu_op  = 2'b01;
        w_alu_src = 1'b1;
        if (r_op_q == c_OP_LOAD) begin
          w_mem_read_en = 1'b1;
          if (ctrl_if.dmem_ready) begin
            w_next = S_WB;
          end
        end else if (r_op_q == c_OP_STORE) begin
          w_mem_write_en = 1'b1;
          if (ctrl_if.dmem_ready) begin
            w_pc_write_en = 1'b1;
            w_retire      = 1'b1;
            w_next        = S_FETCH;
          end
        end else begin
          w_next = S_FETCH;
        end
      end

      S_WB: begin
        w_reg_write_en = 1'b1;
        w_mem_to_reg   = (r_op_q == c_OP_LOAD);
        w_pc_write_en  = 1'b1;
        w_retire       = 1'b1;
        w_next         = S_FETCH;
      end

      default: begin
        w_next = S_RST;
      end
    endcase
  end

  assign ctrl_if.imem_req     = w_imem_req;
  assign ctrl_if.ir_write_en  = w_ir_write_en;
  assign ctrl_if.pc_write_en  = w_pc_write_en;
  assign ctrl_if.pc_src       = w_pc_src;
  assign ctrl_if.jump         = w_jump;
  assign ctrl_if.branch       = w_branch;
  assign ctrl_if.mem_read_en  = w_mem_read_en;
  assign ctrl_if.mem_write_en = w_mem_write_en;
  assign ctrl_if.mem_to_reg   = w_mem_to_reg;
  assign ctrl_if.alu_src      = w_alu_src;
  assign ctrl_if.reg_write_en = w_reg_write_en;
  assign ctrl_if.alu_op       = w_alu_op;
  assign ctrl_if.illegal      = w_illegal;
  assign ctrl_if.retire       = w_retire;
  assign ctrl_if.state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Directed self-checking bench for multicycle_controller.
//                It steps the controller cycle by cycle and compares the
//                state and the packed control word with hand-computed
//                values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  // Control word bit positions:
  // {imem_req, ir_write_en, pc_write_en, pc_src[1:0], jump, branch,
  //  mem_read_en, mem_write_en, mem_to_reg, alu_src, reg_write_en,
  //  alu_op[1:0], illegal, retire}
  localparam logic [15:0] c_IMEM   = 16'h8000;
  localparam logic [15:0] c_IRW    = 16'h4000;
  localparam logic [15:0] c_PCW    = 16'h2000;
  localparam logic [15:0] c_PC_JAL = 16'h1000;
  localparam logic [15:0] c_PC_BR  = 16'h0800;
  localparam logic [15:0] c_JUMP   = 16'h0400;
  localparam logic [15:0] c_BR     = 16'h0200;
  localparam logic [15:0] c_MRD    = 16'h0100;
  localparam logic [15:0] c_MWR    = 16'h0080;
  localparam logic [15:0] c_M2R    = 16'h0040;
  localparam logic [15:0] c_ASRC   = 16'h0020;
  localparam logic [15:0] c_RW     = 16'h0010;
  localparam logic [15:0] c_AOP_B  = 16'h0008;
  localparam logic [15:0] c_AOP_I  = 16'h0004;
  localparam logic [15:0] c_ILL    = 16'h0002;
  localparam logic [15:0] c_RET    = 16'h0001;
  localparam logic [15:0] c_NONE   = 16'h0000;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_BAD    = 7'b1111111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_retire;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus.master)
  );

  logic [15:0] w_obs;
  assign w_obs = {bus.imem_req, bus.ir_write_en, bus.pc_write_en, bus.pc_src,
                  bus.jump, bus.branch, bus.mem_read_en, bus.mem_write_en,
                  bus.mem_to_reg, bus.alu_src, bus.reg_write_en, bus.alu_op,
                  bus.illegal, bus.retire};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.retire) n_retire <= n_retire + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Let combinational outputs settle, then check state and control word.
  task automatic expect_cycle(input string tag, input logic [2:0] exp_state,
                              input logic [15:0] exp_ctrl);
    #1;
    check_eq({tag, ".state"}, {29'd0, bus.state}, {29'd0, exp_state});
    check_eq({tag, ".ctrl"}, {16'd0, w_obs}, {16'd0, exp_ctrl});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_retire = 0;
    rst_n          = 1'b0;
    bus.opcode     = c_OP_R;
    bus.zero       = 1'b0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      expect_cycle("rst_hold", 3'd0, c_NONE);
    end
    rst_n = 1'b1;
    expect_cycle("rst_rel", 3'd0, c_NONE);
    step();

    // R-type with zero-wait memories; opcode changes after DECODE
    expect_cycle("r_fetch", 3'd1, c_IMEM | c_IRW);
    step();
    expect_cycle("r_decode", 3'd2, c_NONE);
    step();
    bus.opcode = c_OP_LOAD;
    expect_cycle("r_exec", 3'd3, c_NONE);
    step();
    expect_cycle("r_wb", 3'd5, c_RW | c_PCW | c_RET);
    check_eq("r_retire_cnt", n_retire, 0);
    step();
    check_eq("r_retire_cnt1", n_retire, 1);

    // LOAD: one imem wait, then two dmem waits
    bus.imem_ready = 1'b0;
    expect_cycle("ld_fetch_wait", 3'd1, c_IMEM);
    step();
    bus.imem_ready = 1'b1;
    expect_cycle("ld_fetch", 3'd1, c_IMEM | c_IRW);
    step();
    expect_cycle("ld_decode", 3'd2, c_NONE);
    step();
    bus.dmem_ready = 1'b0;
    bus.opcode     = c_OP_R;
    expect_cycle("ld_exec", 3'd3, c_AOP_I | c_ASRC);
    step();
    expect_cycle("ld_mem_w1", 3'd4, c_AOP_I | c_ASRC | c_MRD);
    step();
    expect_cycle("ld_mem_w2", 3'd4, c_AOP_I | c_ASRC | c_MRD);
    step();
    bus.dmem_ready = 1'b1;
    expect_cycle("ld_mem_rdy", 3'd4, c_AOP_I | c_ASRC | c_MRD);
    step();
    expect_cycle("ld_wb", 3'd5, c_RW | c_M2R | c_PCW | c_RET);
    step();

    // STORE zero-wait
    bus.opcode = c_OP_STORE;
    expect_cycle("st_fetch", 3'd1, c_IMEM | c_IRW);
    step();
    expect_cycle("st_decode", 3'd2, c_NONE);
    step();
    expect_cycle("st_exec", 3'd3, c_AOP_I | c_ASRC);
    step();
    expect_cycle("st_mem", 3'd4, c_AOP_I | c_ASRC | c_MWR | c_PCW | c_RET);
    step();

    // BRANCH: pc_src follows zero within EXEC
    bus.opcode = c_OP_BRANCH;
    bus.zero   = 1'b1;
    expect_cycle("br_fetch", 3'd1, c_IMEM | c_IRW);
    step();
    expect_cycle("br_decode", 3'd2, c_NONE);
    step();
    expect_cycle("br_exec_z1", 3'd3, c_BR | c_AOP_B | c_PCW | c_PC_BR | c_RET);
    bus.zero = 1'b0;
    expect_cycle("br_exec_z0", 3'd3, c_BR | c_AOP_B | c_PCW | c_RET);
    step();

    // JAL
    bus.opcode = c_OP_JAL;
    expect_cycle("jal_fetch", 3'd1, c_IMEM | c_IRW);
    step();
    expect_cycle("jal_decode", 3'd2, c_NONE);
    step();
    expect_cycle("jal_exec", 3'd3, c_JUMP | c_RW | c_PCW | c_PC_JAL | c_RET);
    step();

    // Illegal opcode retires in DECODE
    bus.opcode = c_OP_BAD;
    expect_cycle("ill_fetch", 3'd1, c_IMEM | c_IRW);
    step();
    expect_cycle("ill_decode", 3'd2, c_ILL | c_PCW | c_RET);
    step();
    expect_cycle("ill_refetch", 3'd1, c_IMEM | c_IRW);
    check_eq("retire_total", n_retire, 6);

    // Async reset during a STORE memory wait
    bus.opcode = c_OP_STORE;
    step();
    expect_cycle("ar_decode", 3'd2, c_NONE);
    step();
    bus.dmem_ready = 1'b0;
    expect_cycle("ar_exec", 3'd3, c_AOP_I | c_ASRC);
    step();
    expect_cycle("ar_mem_wait", 3'd4, c_AOP_I | c_ASRC | c_MWR);
    #1;
    rst_n = 1'b0;
    expect_cycle("ar_async", 3'd0, c_NONE);
    step();
    bus.dmem_ready = 1'b1;
    expect_cycle("ar_held", 3'd0, c_NONE);
    check_eq("ar_no_retire", n_retire, 6);
    rst_n = 1'b1;
    step();
    expect_cycle("ar_refetch", 3'd1, c_IMEM | c_IRW);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
